// File: rtl/crossbar_cfg_seq_if.sv
// Configuration-write channel for the crossbar schedule sequencer.
// The master offers slot writes; the sequencer accepts them while idle.
interface crossbar_cfg_seq_if #(
    parameter int CTRL_W = 5
) ();
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_addr;
    logic [CTRL_W-1:0] cfg_data;

    modport master (
        output cfg_valid,
        output cfg_addr,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_addr,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/crossbar_cfg_seq.sv
// Four-slot schedule sequencer driving a 4x4 crossbar control word.
// Define CROSSBAR_SEQ_HOLD_EN to keep the last word on control while idle.
module crossbar_cfg_seq #(
    parameter int DWELL_W = 8,
    parameter int CTRL_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    crossbar_cfg_seq_if.slave  cfg,
    input  logic               start,
    input  logic               stop,
    input  logic               loop,
    input  logic [DWELL_W-1:0] dwell,
    output logic [CTRL_W-1:0]  control,
    output logic [1:0]         slot,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CTRL_W-1:0]  tbl [4];
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_n;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_n;
    logic [CTRL_W-1:0]  control_n;
    logic [CTRL_W-1:0]  idle_ctrl;
    logic [CTRL_W-1:0]  first_ctrl;
    logic [1:0]         slot_n;
    logic [1:0]         slot_nx;
    logic               busy_n;
    logic               done_n;
    logic               wr;

    assign cfg.cfg_ready = (state == IDLE);
    assign wr            = cfg.cfg_valid && (state == IDLE);
    assign slot_nx       = slot + 2'd1;

    // A write landing on slot 0 at the start edge must be seen by the run.
    assign first_ctrl = (wr && cfg.cfg_addr == 2'd0) ? cfg.cfg_data : tbl[0];

`ifdef CROSSBAR_SEQ_HOLD_EN
    assign idle_ctrl = control;
`else
    assign idle_ctrl = '0;
`endif

    always_comb begin
        state_n   = state;
        dwell_n   = dwell_q;
        cnt_n     = cnt;
        control_n = control;
        slot_n    = slot;
        busy_n    = busy;
        done_n    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_n   = RUN;
                    dwell_n   = dwell;
                    cnt_n     = dwell;
                    control_n = first_ctrl;
                    slot_n    = 2'd0;
                    busy_n    = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n   = IDLE;
                    control_n = idle_ctrl;
                    busy_n    = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (slot == 2'd3 && !loop) begin
                    state_n   = IDLE;
                    control_n = idle_ctrl;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                end else begin
                    cnt_n     = dwell_q;
                    slot_n    = slot_nx;
                    control_n = tbl[slot_nx];
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dwell_q <= '0;
            cnt     <= '0;
            control <= '0;
            slot    <= 2'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                tbl[i] <= '0;
            end
        end else begin
            state   <= state_n;
            dwell_q <= dwell_n;
            cnt     <= cnt_n;
            control <= control_n;
            slot    <= slot_n;
            busy    <= busy_n;
            done    <= done_n;
            if (wr) begin
                tbl[cfg.cfg_addr] <= cfg.cfg_data;
            end
        end
    end

endmodule

// File: tb/tb_crossbar_cfg_seq.sv
// Scoreboard bench for crossbar_cfg_seq: expected per-cycle outputs are
// queued by the stimulus and popped by a monitor while busy or done is high.
module tb_crossbar_cfg_seq;

    localparam int DWELL_W = 8;
    localparam int CTRL_W  = 5;

    typedef struct {
        string            tag;
        logic [CTRL_W-1:0] ctrl;
        logic [1:0]        slot;
        logic              busy;
        logic              done;
        logic              chk_slot;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic               stop;
    logic               loop;
    logic [DWELL_W-1:0] dwell;
    logic [CTRL_W-1:0]  control;
    logic [1:0]         slot;
    logic               busy;
    logic               done;

    exp_t q[$];
    int   ncmp  = 0;
    int   nfail = 0;

    crossbar_cfg_seq_if #(.CTRL_W(CTRL_W)) cfg_bus ();

    crossbar_cfg_seq #(
        .DWELL_W(DWELL_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cfg    (cfg_bus),
        .start  (start),
        .stop   (stop),
        .loop   (loop),
        .dwell  (dwell),
        .control(control),
        .slot   (slot),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

`ifdef CROSSBAR_SEQ_HOLD_EN
    localparam logic [CTRL_W-1:0] END_CTRL  = 5'h1F;
    localparam logic [CTRL_W-1:0] STOP_CTRL = 5'h0A;
`else
    localparam logic [CTRL_W-1:0] END_CTRL  = 5'h00;
    localparam logic [CTRL_W-1:0] STOP_CTRL = 5'h00;
`endif

    // Monitor: every cycle the DUT shows busy or done must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (busy === 1'b1 || done === 1'b1)) begin
            ncmp++;
            if (q.size() == 0) begin
                nfail++;
                $display("FAIL unexpected_output ctrl=%h slot=%0d busy=%b done=%b, expected no activity",
                         control, slot, busy, done);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (control !== e.ctrl || busy !== e.busy || done !== e.done ||
                    (e.chk_slot && slot !== e.slot)) begin
                    nfail++;
                    $display("FAIL %s got ctrl=%h slot=%0d busy=%b done=%b, expected ctrl=%h slot=%0d busy=%b done=%b",
                             e.tag, control, slot, busy, done, e.ctrl, e.slot, e.busy, e.done);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        ncmp++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input logic [CTRL_W-1:0] c, input logic [1:0] s,
                        input logic b, input logic d, input logic cs);
        exp_t e;
        e.tag = tag; e.ctrl = c; e.slot = s; e.busy = b; e.done = d; e.chk_slot = cs;
        q.push_back(e);
    endtask

    task automatic write(input logic [1:0] a, input logic [CTRL_W-1:0] d);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_addr  = a;
        cfg_bus.cfg_data  = d;
        step();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && q.size() != 0; i++) step();
        ncmp++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL %s_timeout got %0d pending, expected 0", tag, q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [CTRL_W-1:0] w [4];
        w[0] = 5'h01; w[1] = 5'h0A; w[2] = 5'h15; w[3] = 5'h1F;

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; dwell = '0;
        cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_addr = '0; cfg_bus.cfg_data = '0;
        #3;
        check("rst_control", 32'(control), 32'h0);
        check("rst_slot", 32'(slot), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'h1);
        step(); step();
        rst_n = 1'b1;
        step();

        // Full non-looping run, dwell=2, with a write attempted mid-run.
        for (int i = 0; i < 4; i++) write(2'(i), w[i]);
        for (int s = 0; s < 4; s++)
            for (int k = 0; k < 3; k++) push("run1", w[s], 2'(s), 1'b1, 1'b0, 1'b1);
        push("run1_done", END_CTRL, 2'd3, 1'b0, 1'b1, 1'b0);
        dwell = 8'd2; loop = 1'b0; start = 1'b1;
        step();
        start = 1'b0; dwell = 8'd9;
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_addr = 2'd2; cfg_bus.cfg_data = 5'h07;
        step();
        check("run_cfg_ready", 32'(cfg_bus.cfg_ready), 32'h0);
        step(); step(); step();
        cfg_bus.cfg_valid = 1'b0;
        drain("run1");
        step();
        check("run1_idle_busy", 32'(busy), 32'h0);
        check("run1_idle_done", 32'(done), 32'h0);
        check("run1_idle_ctrl", 32'(control), 32'(END_CTRL));

        // Looping run, dwell=0, ten cycles then stop.
        for (int i = 0; i < 10; i++) push("loop", w[i % 4], 2'(i % 4), 1'b1, 1'b0, 1'b1);
        dwell = 8'd0; loop = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0; loop = 1'b0;
        check("loop_stop_busy", 32'(busy), 32'h0);
        check("loop_stop_done", 32'(done), 32'h0);
        drain("loop");

        // Stop in slot 1 with dwell=5.
        for (int i = 0; i < 6; i++) push("stop_s0", w[0], 2'd0, 1'b1, 1'b0, 1'b1);
        push("stop_s1", w[1], 2'd1, 1'b1, 1'b0, 1'b1);
        dwell = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_done", 32'(done), 32'h0);
        check("stop_ctrl", 32'(control), 32'(STOP_CTRL));
        drain("stop");

        // start and stop together in IDLE.
        start = 1'b1; stop = 1'b1;
        step();
        check("ss_busy", 32'(busy), 32'h0);
        check("ss_cfg_ready", 32'(cfg_bus.cfg_ready), 32'h1);
        start = 1'b0; stop = 1'b0;
        step();
        check("ss_busy2", 32'(busy), 32'h0);

        // Asynchronous reset mid-run.
        for (int i = 0; i < 3; i++) push("prerst", w[0], 2'd0, 1'b1, 1'b0, 1'b1);
        dwell = 8'd3; loop = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        #6;
        rst_n = 1'b0;
        #1;
        check("arst_control", 32'(control), 32'h0);
        check("arst_slot", 32'(slot), 32'h0);
        check("arst_busy", 32'(busy), 32'h0);
        check("arst_done", 32'(done), 32'h0);
        check("arst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'h1);
        check("arst_drained", 32'(q.size()), 32'h0);
        q.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1; loop = 1'b0;
        step();

        // Cleared table, plus a slot-0 write coinciding with start.
        push("post_s0", 5'h11, 2'd0, 1'b1, 1'b0, 1'b1);
        for (int s = 1; s < 4; s++) push("post_clr", 5'h00, 2'(s), 1'b1, 1'b0, 1'b1);
        push("post_done", 5'h00, 2'd3, 1'b0, 1'b1, 1'b0);
        dwell = 8'd0; start = 1'b1;
        cfg_bus.cfg_valid = 1'b1; cfg_bus.cfg_addr = 2'd0; cfg_bus.cfg_data = 5'h11;
        step();
        start = 1'b0; cfg_bus.cfg_valid = 1'b0;
        drain("post");
        step();
        check("post_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
